// File: rtl/alu_pkg.sv
// alu_pkg: shared widths and the stage-1 payload for the pipelined subtractor
package alu_pkg;
  localparam int WIDTH = 32;
  localparam int HALF = WIDTH / 2;
  typedef struct packed {
    logic [HALF-1:0] d_lo;
    logic            c16;
    logic [HALF-1:0] a_hi;
    logic [HALF-1:0] nb_hi;
    logic            sign_a;
    logic            sign_b;
  } s1_t;
endpackage

// File: rtl/bk_sub32_pipe_if.sv
// bk_sub32_pipe_if: operand/result handshake bundle for bk_sub32_pipe
interface bk_sub32_pipe_if;
  import alu_pkg::*;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Ovf;
  logic             Zero;
  modport master(output in_valid, A, B, Bin, out_ready, input in_ready, out_valid, Diff, Bout, Ovf, Zero);
  modport slave(input in_valid, A, B, Bin, out_ready, output in_ready, out_valid, Diff, Bout, Ovf, Zero);
endinterface

// File: rtl/bk_add16.sv
// bk_add16: combinational 16-bit Brent-Kung adder
module bk_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  // cin is folded into bit 0's generate, so g[i] ends up as the carry out of bit i
  function automatic logic [16:0] bk(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [15:0] g, p, h;
    g = x & y;
    p = x ^ y;
    h = p;
    g[0] = g[0] | (p[0] & ci);
    for (int l = 0; l < 4; l++)
      for (int i = (2 << l) - 1; i < 16; i += 2 << l) begin
        g[4'(i)] = g[4'(i)] | (p[4'(i)] & g[4'(i - (1 << l))]);
        p[4'(i)] = p[4'(i)] & p[4'(i - (1 << l))];
      end
    for (int l = 2; l >= 0; l--)
      for (int i = 3 * (1 << l) - 1; i < 16; i += 2 << l) begin
        g[4'(i)] = g[4'(i)] | (p[4'(i)] & g[4'(i - (1 << l))]);
        p[4'(i)] = p[4'(i)] & p[4'(i - (1 << l))];
      end
    return {g[15], h ^ {g[14:0], ci}};
  endfunction
  assign {cout, s} = bk(a, b, cin);
endmodule

// File: rtl/bk_sub32_pipe.sv
// bk_sub32_pipe: 2-stage valid/ready subtractor, A - B - Bin computed as A + ~B + ~Bin
module bk_sub32_pipe
  import alu_pkg::*;
(
  input logic           clk,
  input logic           rst,
  bk_sub32_pipe_if.slave bus
);
  s1_t              s1, s1_n;
  logic             s1_valid, s2_valid, s1_adv, s2_adv;
  logic [HALF-1:0]  d_lo, d_hi;
  logic             c16, c32;
  logic [WIDTH-1:0] diff_n;
  bk_add16 u_lo (.a(bus.A[HALF-1:0]), .b(~bus.B[HALF-1:0]), .cin(~bus.Bin), .s(d_lo), .cout(c16));
  bk_add16 u_hi (.a(s1.a_hi), .b(s1.nb_hi), .cin(s1.c16), .s(d_hi), .cout(c32));
  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = s2_valid;
  assign diff_n = {d_hi, s1.d_lo};
  assign s1_n = '{d_lo: d_lo, c16: c16, a_hi: bus.A[WIDTH-1:HALF], nb_hi: ~bus.B[WIDTH-1:HALF],
                  sign_a: bus.A[WIDTH-1], sign_b: bus.B[WIDTH-1]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1       <= '0;
      bus.Diff <= '0;
      bus.Bout <= 1'b0;
      bus.Ovf  <= 1'b0;
      bus.Zero <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= bus.in_valid;
      if (s1_adv && bus.in_valid) s1 <= s1_n;
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        bus.Diff <= diff_n;
        bus.Bout <= ~c32;
        bus.Ovf  <= (s1.sign_a != s1.sign_b) && (diff_n[WIDTH-1] != s1.sign_a);
        bus.Zero <= diff_n == '0;
      end
    end
endmodule

// File: tb/tb_bk_sub32_pipe.sv
// tb_bk_sub32_pipe: directed and randomized checks of bk_sub32_pipe against an arithmetic model
module tb_bk_sub32_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bk_sub32_pipe_if bus();
  bk_sub32_pipe dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic [34:0] q[$];
  logic [34:0] e, held;
  logic hold = 1'b0;
  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // result packed as {diff, bout, ovf, zero}
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] w;
    w = {1'b0, a} - {1'b0, b} - 33'(bin);
    return {w[31:0], w[32], (a[31] != b[31]) && (w[31] != a[31]), w[31:0] == 32'd0};
  endfunction
  function automatic logic [31:0] pick();
    int r;
    r = int'($urandom % 6);
    return r == 0 ? 32'd0 : r == 1 ? 32'hFFFFFFFF : r == 2 ? 32'h80000000 : r == 3 ? 32'h7FFFFFFF : $urandom;
  endfunction
  function automatic logic [34:0] outs();
    return {bus.Diff, bus.Bout, bus.Ovf, bus.Zero};
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_valid", 35'(bus.out_valid), 35'd1);
        chk("stall_hold", outs(), held);
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.A, bus.B, bus.Bin));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got %h expected none", outs());
        end else begin
          e = q.pop_front();
          chk("stream_result", outs(), e);
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      held = outs();
    end
  end
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.Bin = bin;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input logic [34:0] exp);
    send(a, b, bin);
    chk({name, "_lat1"}, 35'(bus.out_valid), 35'd0);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 35'(bus.out_valid), 35'd1);
    chk(name, outs(), exp);
  endtask
  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_queue", 35'(q.size()), 35'd0);
    chk("drain_empty", 35'(bus.out_valid), 35'd0);
  endtask
  logic [31:0] sa[4];
  logic [31:0] sb[4];
  initial begin
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Bin = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 35'(bus.out_valid), 35'd0);
    chk("reset_outs", outs(), 35'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", 35'(bus.in_ready), 35'd1);
    directed("sub_5_3", 32'd5, 32'd3, 1'b0, {32'h00000002, 3'b000});
    directed("sub_0_1", 32'd0, 32'd1, 1'b0, {32'hFFFFFFFF, 3'b100});
    directed("ovf_min", 32'h80000000, 32'd1, 1'b0, {32'h7FFFFFFF, 3'b010});
    directed("cross_half", 32'h00010000, 32'h00000001, 1'b1, {32'h0000FFFE, 3'b000});
    directed("zero", 32'h12345678, 32'h12345678, 1'b0, {32'h00000000, 3'b001});
    drain();
    sa = '{32'd100, 32'hDEADBEEF, 32'h00000000, 32'h7FFFFFFF};
    sb = '{32'd1, 32'h00001234, 32'h00000005, 32'hFFFFFFFF};
    bus.out_ready = 1'b0;
    send(sa[0], sb[0], 1'b0);
    send(sa[1], sb[1], 1'b1);
    bus.in_valid = 1'b1;
    bus.A = sa[2];
    bus.B = sb[2];
    bus.Bin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_in_ready", 35'(bus.in_ready), 35'd0);
      chk("full_diff", 35'(bus.Diff), 35'(model(sa[0], sb[0], 1'b0) >> 3));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(sa[2], sb[2], 1'b0);
    send(sa[3], sb[3], 1'b1);
    drain();
    bus.out_ready = 1'b0;
    send(32'd9, 32'd4, 1'b0);
    send(32'd7, 32'd2, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 35'(bus.out_valid), 35'd0);
    chk("rst_mid_outs", outs(), 35'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_in_ready", 35'(bus.in_ready), 35'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_no_stale", 35'(bus.out_valid), 35'd0);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 400; k++) begin
      bus.in_valid = ($urandom % 4) != 0;
      bus.A = pick();
      bus.B = pick();
      bus.Bin = 1'($urandom);
      bus.out_ready = ($urandom % 3) != 0;
      @(posedge clk);
      #1;
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
